// File: rtl/ab_pkg.sv
// Shared definitions for the parametrised A/B scorer.
// Contents:
//   state_t   - FSM state encoding (IDLE..LOSE); codes 6 and 7 are unused.
//   DIGIT_MAX - largest legal digit value.
//   cnt_w     - width of an A/B count for a given number of digits.
//   idx_w     - width of a digit index (at least 1 bit).
package ab_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SCORE  = 3'd2,
        ST_REPORT = 3'd3,
        ST_WIN    = 3'd4,
        ST_LOSE   = 3'd5
    } state_t;

    localparam int DIGIT_MAX = 9;

    // Enough bits to count 0..n matches.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Enough bits to index digits 0..n-1, never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ab_digit_match.sv
// Combinational scoring of one guess digit against the whole secret.
// Ports:
//   idx    - index of the guess digit being scored (0 = leftmost)
//   guess  - packed guess, digit i at [i*DIGIT_W +: DIGIT_W]
//   secret - packed secret, same layout
//   hit_a  - guess[idx] equals secret[idx]
//   hit_b  - no hit_a, but guess[idx] equals secret[j] for some j != idx
//   dup    - guess[idx] is out of range or repeats an earlier guess digit
module ab_digit_match
    import ab_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_W    = 4,
    localparam int IDX_W      = idx_w(NUM_DIGITS)
) (
    input  logic [IDX_W-1:0]              idx,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
    output logic                          hit_a,
    output logic                          hit_b,
    output logic                          dup
);

    logic [DIGIT_W-1:0] g_i_s;
    logic [DIGIT_W-1:0] s_i_s;
    logic               in_secret_s;
    logic               seen_before_s;

    // Compare the selected guess digit against every secret digit and every earlier guess digit.
    always_comb begin
        g_i_s         = guess[idx*DIGIT_W +: DIGIT_W];
        s_i_s         = secret[idx*DIGIT_W +: DIGIT_W];
        in_secret_s   = 1'b0;
        seen_before_s = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            in_secret_s   = in_secret_s |
                            ((IDX_W'(j) != idx) && (secret[j*DIGIT_W +: DIGIT_W] == g_i_s));
            seen_before_s = seen_before_s |
                            ((IDX_W'(j) < idx) && (guess[j*DIGIT_W +: DIGIT_W] == g_i_s));
        end
        hit_a = (g_i_s == s_i_s);
        hit_b = !hit_a && in_secret_s;
        dup   = (int'(g_i_s) > DIGIT_MAX) || seen_before_s;
    end

endmodule

// File: rtl/ab_scorer_param.sv
// N-digit 1A2B game core: holds a secret, scores guesses one digit per
// cycle, counts guesses and ends the game on WIN or LOSE.
// Ports:
//   in_clk        - system clock, rising edge
//   in_restart    - synchronous active-high reset, overrides everything
//   in_loadtest   - load in_ans as the secret (IDLE/WIN/LOSE only)
//   in_enter      - submit in_ans as a guess (WAIT only)
//   in_ans        - packed digits, digit i at [i*DIGIT_W +: DIGIT_W], 0 = leftmost
//   out_Anum      - A count of the last valid guess
//   out_Bnum      - B count of the last valid guess
//   out_state     - current FSM state code
//   out_valid     - one-cycle pulse, result ready
//   out_err       - one-cycle pulse, secret or guess rejected
//   out_guess_cnt - number of valid guesses in the current game
module ab_scorer_param
    import ab_pkg::*;
#(
    parameter  int NUM_DIGITS  = 4,
    parameter  int DIGIT_W     = 4,
    parameter  int MAX_GUESSES = 8,
    localparam int CNT_W       = cnt_w(NUM_DIGITS)
) (
    input  logic                          in_clk,
    input  logic                          in_restart,
    input  logic                          in_loadtest,
    input  logic                          in_enter,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] in_ans,
    output logic [CNT_W-1:0]              out_Anum,
    output logic [CNT_W-1:0]              out_Bnum,
    output logic [2:0]                    out_state,
    output logic                          out_valid,
    output logic                          out_err,
    output logic [7:0]                    out_guess_cnt
);

    localparam int               IDX_W       = idx_w(NUM_DIGITS);
    localparam int               W           = NUM_DIGITS * DIGIT_W;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] ALL_HIT     = CNT_W'(NUM_DIGITS);
    localparam logic [7:0]       GUESS_LIMIT = 8'(MAX_GUESSES);

    state_t             state_r;
    state_t             next_state_s;
    logic [W-1:0]       secret_r;
    logic [W-1:0]       guess_r;
    logic [IDX_W-1:0]   idx_r;
    logic [CNT_W-1:0]   acc_a_r;
    logic [CNT_W-1:0]   acc_b_r;
    logic               dup_r;

    logic               ans_ok_s;
    logic               hit_a_s;
    logic               hit_b_s;
    logic               dup_s;
    logic [7:0]         cnt_next_s;

    // Action strobes decoded by the FSM, consumed by the datapath.
    logic               load_s;
    logic               load_err_s;
    logic               take_guess_s;
    logic               step_s;
    logic               report_ok_s;
    logic               report_err_s;

    ab_digit_match #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) u_match (
        .idx    (idx_r),
        .guess  (guess_r),
        .secret (secret_r),
        .hit_a  (hit_a_s),
        .hit_b  (hit_b_s),
        .dup    (dup_s)
    );

    // A candidate secret is usable only if every digit is in range and all digits differ.
    always_comb begin
        ans_ok_s = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ans_ok_s = ans_ok_s & (int'(in_ans[i*DIGIT_W +: DIGIT_W]) <= DIGIT_MAX);
            for (int j = 0; j < i; j++) begin
                ans_ok_s = ans_ok_s &
                           (in_ans[i*DIGIT_W +: DIGIT_W] != in_ans[j*DIGIT_W +: DIGIT_W]);
            end
        end
    end

    // State register; restart wins over any transition.
    always_ff @(posedge in_clk) begin
        if (in_restart) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and action decode.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_err_s   = 1'b0;
        take_guess_s = 1'b0;
        step_s       = 1'b0;
        report_ok_s  = 1'b0;
        report_err_s = 1'b0;
        cnt_next_s   = out_guess_cnt + 8'd1;
        case (state_r)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (in_loadtest) begin
                    if (ans_ok_s) begin
                        load_s       = 1'b1;
                        next_state_s = ST_WAIT;
                    end else begin
                        load_err_s   = 1'b1;
                        next_state_s = state_r;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_WAIT: begin
                if (in_enter) begin
                    take_guess_s = 1'b1;
                    next_state_s = ST_SCORE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_SCORE: begin
                step_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    next_state_s = ST_REPORT;
                end else begin
                    next_state_s = ST_SCORE;
                end
            end
            ST_REPORT: begin
                if (dup_r) begin
                    report_err_s = 1'b1;
                    next_state_s = ST_WAIT;
                end else begin
                    report_ok_s = 1'b1;
                    if (acc_a_r == ALL_HIT) begin
                        next_state_s = ST_WIN;
                    end else if (cnt_next_s == GUESS_LIMIT) begin
                        next_state_s = ST_LOSE;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: secret/guess latches, per-digit accumulation and registered result outputs.
    always_ff @(posedge in_clk) begin
        if (in_restart) begin
            secret_r      <= '0;
            guess_r       <= '0;
            idx_r         <= '0;
            acc_a_r       <= '0;
            acc_b_r       <= '0;
            dup_r         <= 1'b0;
            out_Anum      <= '0;
            out_Bnum      <= '0;
            out_valid     <= 1'b0;
            out_err       <= 1'b0;
            out_guess_cnt <= 8'd0;
        end else begin
            out_valid <= report_ok_s;
            out_err   <= load_err_s | report_err_s;
            if (load_s) begin
                secret_r      <= in_ans;
                out_guess_cnt <= 8'd0;
            end
            if (take_guess_s) begin
                guess_r <= in_ans;
                idx_r   <= '0;
                acc_a_r <= '0;
                acc_b_r <= '0;
                dup_r   <= 1'b0;
            end
            if (step_s) begin
                acc_a_r <= acc_a_r + CNT_W'(hit_a_s);
                acc_b_r <= acc_b_r + CNT_W'(hit_b_s);
                dup_r   <= dup_r | dup_s;
                idx_r   <= idx_r + IDX_W'(1);
            end
            if (report_ok_s) begin
                out_Anum      <= acc_a_r;
                out_Bnum      <= acc_b_r;
                out_guess_cnt <= cnt_next_s;
            end
        end
    end

    assign out_state = state_r;

endmodule

// File: tb/tb_ab_scorer_param.sv
// Directed bench for ab_scorer_param: default 4-digit core, a 3-guess
// core for the LOSE path, and a 6-digit core for parameter scaling.
module tb_ab_scorer_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4 digits, 8 guesses
    logic        r4, l4, e4;
    logic [15:0] ans4;
    logic [2:0]  a4, b4, st4;
    logic        v4, err4;
    logic [7:0]  cnt4;

    // 4 digits, 3 guesses
    logic        r3, l3, e3;
    logic [15:0] ans3;
    logic [2:0]  a3, b3, st3;
    logic        v3, err3;
    logic [7:0]  cnt3;

    // 6 digits, 8 guesses
    logic        r6, l6, e6;
    logic [23:0] ans6;
    logic [2:0]  a6, b6, st6;
    logic        v6, err6;
    logic [7:0]  cnt6;

    ab_scorer_param #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_GUESSES(8)) dut4 (
        .in_clk(clk), .in_restart(r4), .in_loadtest(l4), .in_enter(e4), .in_ans(ans4),
        .out_Anum(a4), .out_Bnum(b4), .out_state(st4), .out_valid(v4), .out_err(err4),
        .out_guess_cnt(cnt4)
    );

    ab_scorer_param #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_GUESSES(3)) dut3 (
        .in_clk(clk), .in_restart(r3), .in_loadtest(l3), .in_enter(e3), .in_ans(ans3),
        .out_Anum(a3), .out_Bnum(b3), .out_state(st3), .out_valid(v3), .out_err(err3),
        .out_guess_cnt(cnt3)
    );

    ab_scorer_param #(.NUM_DIGITS(6), .DIGIT_W(4), .MAX_GUESSES(8)) dut6 (
        .in_clk(clk), .in_restart(r6), .in_loadtest(l6), .in_enter(e6), .in_ans(ans6),
        .out_Anum(a6), .out_Bnum(b6), .out_state(st6), .out_valid(v6), .out_err(err6),
        .out_guess_cnt(cnt6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] p4(input logic [3:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [23:0] p6(input logic [3:0] d0, d1, d2, d3, d4, d5);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    // Submit a guess for one cycle and wait until the result pulse is visible.
    task automatic g4(input logic [15:0] g);
        ans4 = g; e4 = 1'b1;
        step(1);
        e4 = 1'b0;
        step(5);
    endtask

    task automatic g3(input logic [15:0] g);
        ans3 = g; e3 = 1'b1;
        step(1);
        e3 = 1'b0;
        step(5);
    endtask

    initial begin
        r4 = 1'b1; l4 = 1'b0; e4 = 1'b0; ans4 = 16'd0;
        r3 = 1'b1; l3 = 1'b0; e3 = 1'b0; ans3 = 16'd0;
        r6 = 1'b1; l6 = 1'b0; e6 = 1'b0; ans6 = 24'd0;
        step(3);
        r4 = 1'b0; r3 = 1'b0; r6 = 1'b0;

        chk("rst_state", 32'(st4), 32'd0);
        chk("rst_a", 32'(a4), 32'd0);
        chk("rst_b", 32'(b4), 32'd0);
        chk("rst_valid", 32'(v4), 32'd0);
        chk("rst_err", 32'(err4), 32'd0);
        chk("rst_cnt", 32'(cnt4), 32'd0);
        chk("rst_state3", 32'(st3), 32'd0);
        chk("rst_state6", 32'(st6), 32'd0);

        // Load secret 2345, then the winning guess with stepwise latency checks.
        ans4 = p4(4'd2, 4'd3, 4'd4, 4'd5); l4 = 1'b1;
        step(1);
        l4 = 1'b0;
        chk("load_wait", 32'(st4), 32'd1);
        ans4 = p4(4'd2, 4'd3, 4'd4, 4'd5); e4 = 1'b1;
        step(1);
        e4 = 1'b0;
        chk("score_state", 32'(st4), 32'd2);
        step(3);
        chk("early_valid", 32'(v4), 32'd0);
        step(1);
        chk("report_state", 32'(st4), 32'd3);
        chk("report_valid_lo", 32'(v4), 32'd0);
        step(1);
        chk("win_valid", 32'(v4), 32'd1);
        chk("win_a", 32'(a4), 32'd4);
        chk("win_b", 32'(b4), 32'd0);
        chk("win_state", 32'(st4), 32'd4);
        chk("win_cnt", 32'(cnt4), 32'd1);
        step(1);
        chk("valid_pulse", 32'(v4), 32'd0);

        // Invalid secret in WIN: error, stay in WIN.
        ans4 = p4(4'd1, 4'd1, 4'd2, 4'd3); l4 = 1'b1;
        step(1);
        l4 = 1'b0;
        chk("win_bad_err", 32'(err4), 32'd1);
        chk("win_bad_state", 32'(st4), 32'd4);
        step(1);
        chk("err_pulse", 32'(err4), 32'd0);

        // New game from WIN.
        ans4 = p4(4'd2, 4'd3, 4'd4, 4'd5); l4 = 1'b1;
        step(1);
        l4 = 1'b0;
        chk("reload_state", 32'(st4), 32'd1);
        chk("reload_cnt", 32'(cnt4), 32'd0);
        chk("reload_a_hold", 32'(a4), 32'd4);

        g4(p4(4'd5, 4'd4, 4'd3, 4'd2));
        chk("g1_valid", 32'(v4), 32'd1);
        chk("g1_a", 32'(a4), 32'd0);
        chk("g1_b", 32'(b4), 32'd4);
        chk("g1_cnt", 32'(cnt4), 32'd1);
        chk("g1_state", 32'(st4), 32'd1);

        g4(p4(4'd5, 4'd4, 4'd2, 4'd3));
        chk("g2_a", 32'(a4), 32'd0);
        chk("g2_b", 32'(b4), 32'd4);
        chk("g2_cnt", 32'(cnt4), 32'd2);
        chk("g2_state", 32'(st4), 32'd1);

        g4(p4(4'd5, 4'd4, 4'd2, 4'd8));
        chk("g3_a", 32'(a4), 32'd0);
        chk("g3_b", 32'(b4), 32'd3);
        chk("g3_cnt", 32'(cnt4), 32'd3);
        chk("g3_state", 32'(st4), 32'd1);

        // Repeated digit in a guess.
        g4(p4(4'd1, 4'd1, 4'd2, 4'd3));
        chk("dup_err", 32'(err4), 32'd1);
        chk("dup_valid", 32'(v4), 32'd0);
        chk("dup_a", 32'(a4), 32'd0);
        chk("dup_b", 32'(b4), 32'd3);
        chk("dup_cnt", 32'(cnt4), 32'd3);
        chk("dup_state", 32'(st4), 32'd1);

        // Out-of-range digit in a guess.
        g4(p4(4'd2, 4'd3, 4'd4, 4'd10));
        chk("range_err", 32'(err4), 32'd1);
        chk("range_valid", 32'(v4), 32'd0);
        chk("range_b", 32'(b4), 32'd3);
        chk("range_cnt", 32'(cnt4), 32'd3);

        // Restart in the middle of scoring.
        ans4 = p4(4'd2, 4'd3, 4'd4, 4'd5); e4 = 1'b1;
        step(1);
        e4 = 1'b0;
        step(2);
        r4 = 1'b1;
        step(1);
        r4 = 1'b0;
        chk("mid_rst_state", 32'(st4), 32'd0);
        chk("mid_rst_a", 32'(a4), 32'd0);
        chk("mid_rst_b", 32'(b4), 32'd0);
        chk("mid_rst_cnt", 32'(cnt4), 32'd0);
        chk("mid_rst_valid", 32'(v4), 32'd0);
        chk("mid_rst_err", 32'(err4), 32'd0);
        step(5);
        chk("mid_rst_no_valid", 32'(v4), 32'd0);
        chk("mid_rst_idle", 32'(st4), 32'd0);

        // Invalid secret in IDLE, then in_enter ignored in IDLE.
        ans4 = p4(4'd7, 4'd7, 4'd0, 4'd1); l4 = 1'b1;
        step(1);
        l4 = 1'b0;
        chk("idle_bad_err", 32'(err4), 32'd1);
        chk("idle_bad_state", 32'(st4), 32'd0);
        e4 = 1'b1;
        step(2);
        e4 = 1'b0;
        chk("idle_enter_ign", 32'(st4), 32'd0);

        // Three-guess limit leads to LOSE.
        ans3 = p4(4'd0, 4'd1, 4'd2, 4'd3); l3 = 1'b1;
        step(1);
        l3 = 1'b0;
        chk("lose_load", 32'(st3), 32'd1);
        g3(p4(4'd4, 4'd5, 4'd6, 4'd7));
        chk("lose_g1_valid", 32'(v3), 32'd1);
        chk("lose_g1_cnt", 32'(cnt3), 32'd1);
        chk("lose_g1_state", 32'(st3), 32'd1);
        g3(p4(4'd4, 4'd5, 4'd6, 4'd7));
        chk("lose_g2_cnt", 32'(cnt3), 32'd2);
        chk("lose_g2_state", 32'(st3), 32'd1);
        g3(p4(4'd4, 4'd5, 4'd6, 4'd7));
        chk("lose_g3_valid", 32'(v3), 32'd1);
        chk("lose_g3_a", 32'(a3), 32'd0);
        chk("lose_g3_b", 32'(b3), 32'd0);
        chk("lose_g3_cnt", 32'(cnt3), 32'd3);
        chk("lose_g3_state", 32'(st3), 32'd5);
        ans3 = p4(4'd4, 4'd5, 4'd6, 4'd7); e3 = 1'b1;
        step(6);
        e3 = 1'b0;
        chk("lose_enter_state", 32'(st3), 32'd5);
        chk("lose_enter_cnt", 32'(cnt3), 32'd3);
        chk("lose_enter_valid", 32'(v3), 32'd0);
        ans3 = p4(4'd0, 4'd1, 4'd2, 4'd3); l3 = 1'b1;
        step(1);
        l3 = 1'b0;
        chk("lose_reload_state", 32'(st3), 32'd1);
        chk("lose_reload_cnt", 32'(cnt3), 32'd0);

        // Six-digit core: latency N+1 and 2A2B.
        ans6 = p6(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5); l6 = 1'b1;
        step(1);
        l6 = 1'b0;
        chk("n6_load", 32'(st6), 32'd1);
        ans6 = p6(4'd0, 4'd1, 4'd5, 4'd4, 4'd9, 4'd8); e6 = 1'b1;
        step(1);
        e6 = 1'b0;
        step(6);
        chk("n6_early_valid", 32'(v6), 32'd0);
        chk("n6_report", 32'(st6), 32'd3);
        step(1);
        chk("n6_valid", 32'(v6), 32'd1);
        chk("n6_a", 32'(a6), 32'd2);
        chk("n6_b", 32'(b6), 32'd2);
        chk("n6_cnt", 32'(cnt6), 32'd1);
        chk("n6_state", 32'(st6), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ab_scorer_param.md
Name: ab_scorer_param

Overview:
- Parametrised, single-clock successor to the fixed 4-digit 1A2B game core.
- Holds an N-digit secret and accepts guesses. Scores each guess sequentially, one digit per cycle, and reports A (right digit, right place) and B (right digit, wrong place).
- Adds input validation, a guess counter and win/lose termination.
- Sits between the switch/button front end and the 7-segment result display.

Parameters:
- NUM_DIGITS, 4, digits per secret/guess; legal range 1..10.
- DIGIT_W, 4, bits per digit; legal digit values 0..9.
- MAX_GUESSES, 8, guesses allowed before LOSE; legal range 1..255.

Ports:
- in_clk  in  1  single system clock, rising edge.
- in_restart  in  1  synchronous, active-high reset; highest priority.
- in_loadtest  in  1  level; load in_ans as the secret (IDLE/WIN/LOSE only).
- in_enter  in  1  level; submit in_ans as a guess (WAIT only).
- in_ans  in  NUM_DIGITS*DIGIT_W  digit i at [i*DIGIT_W +: DIGIT_W]; digit 0 = leftmost.
- out_Anum  out  CNT_W  A count of last valid guess.
- out_Bnum  out  CNT_W  B count of last valid guess.
- out_state  out  3  FSM state encoding.
- out_valid  out  1  one-cycle pulse, result ready.
- out_err  out  1  one-cycle pulse, rejected secret or guess.
- out_guess_cnt  out  8  valid guesses taken.

Behaviour:
- CNT_W = $clog2(NUM_DIGITS+1).
- Reset (in_restart=1 at an edge): state=IDLE; all outputs 0; secret, guess and counters cleared. Reset overrides every other input in every state, including mid-SCORE.
- States and encoding: IDLE=0, WAIT=1, SCORE=2, REPORT=3, WIN=4, LOSE=5. Codes 6 and 7 are unreachable and return to IDLE.
- Validity rule, for secret and guess alike: every digit ≤9 and all digits pairwise distinct.
- IDLE:
  - in_loadtest=1 with valid in_ans: latch secret, clear out_guess_cnt, go to WAIT.
  - in_loadtest=1 with invalid in_ans: out_err pulse next cycle, stay in IDLE.
  - in_enter is ignored.
- WAIT:
  - in_enter=1: latch in_ans into the guess register, clear the A/B accumulators and index i, go to SCORE.
  - in_loadtest is ignored.
- SCORE: one digit per cycle, i = 0..NUM_DIGITS-1.
  - A += 1 if guess[i]==secret[i].
  - Else B += 1 if guess[i]==secret[j] for some j≠i.
  - dup flag set if guess[i]>9, or guess[i]==guess[j] for any j<i.
  - After i=NUM_DIGITS-1, go to REPORT.
- REPORT: lasts one cycle.
  - dup set: out_err=1; out_Anum/out_Bnum and the counter are unchanged; next state WAIT.
  - Otherwise: out_valid=1; out_Anum/out_Bnum update from the accumulators in the same cycle; out_guess_cnt += 1.
  - Next state: WIN if A==NUM_DIGITS; else LOSE if the new count==MAX_GUESSES; else WAIT.
- Latency: in_enter sampled at edge k gives out_valid high during cycle k+NUM_DIGITS+1.
- Guesses are not queued: in_enter held high re-submits the same guess on every return to WAIT. The front end is responsible for edge-detecting buttons.
- WIN/LOSE:
  - Outputs hold.
  - in_loadtest with a valid secret starts a new game, same rule as IDLE.
  - in_loadtest with an invalid secret gives out_err and no state change.
- out_Anum/out_Bnum hold their last value until the next valid REPORT; they are cleared only by reset.
- in_ans is sampled only at the latch edge; changes during SCORE have no effect.

Decomposition:
- Package ab_pkg: the state enum/localparams (IDLE..LOSE), CNT_W function, and the digit max constant (9).
- Sub-module ab_digit_match:
  - Combinational, parameterised by NUM_DIGITS/DIGIT_W.
  - Inputs: index i, guess, secret.
  - Outputs: hitA, hitB, dup.
- The top holds the FSM, registers and counters.

Test Plan:
- Reset 3 cycles; secret {2,3,4,5}; guess {2,3,4,5} → after 5 cycles out_valid=1, A=4, B=0, out_state=4 (WIN), out_guess_cnt=1.
- Secret {2,3,4,5}; guesses {5,4,3,2}, {5,4,2,3}, {5,4,2,8} → 0A4B, 0A4B, 0A3B; out_guess_cnt 1, 2, 3; state returns to WAIT each time.
- Guess {1,1,2,3}, then guess {2,3,4,A(10)} → out_err pulse each time, no out_valid, A/B and out_guess_cnt unchanged. Secret {7,7,0,1} in IDLE → out_err, stay in IDLE.
- MAX_GUESSES=3, secret {0,1,2,3}, three guesses {4,5,6,7} → third REPORT gives 0A0B and state LOSE. A fourth in_enter is ignored.
- in_restart asserted during SCORE cycle 2 → next cycle IDLE, all outputs 0, no out_valid.
- NUM_DIGITS=6, DIGIT_W=4: secret {0,1,2,3,4,5}, guess {0,1,5,4,9,8} → valid after 7 cycles, A=2, B=2.
